// File: rtl/mask_wb_packer.sv
// mask_wb_packer: packs variable-width mask result beats into DW_B-bit mask words for the mask register file.
// Latency: a write appears on wr_* the cycle after the beat that completes it; the trailing partial word needs one extra FLUSH cycle.
// Backpressure: in_ready is high only in RUN, where one beat per cycle is accepted; IDLE and FLUSH hold it low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, start_vd, busy    operation start (ignored while busy) and activity flag
//   in_valid/in_ready        beat handshake; in_bits/in_cnt/in_last carry the beat
//   wr_en/wr_addr/wr_off     per-bit write enables, register and word offset
//   wr_data_in               packed word in the low DW_B bits, upper bits zero
//   done, ovf                completion pulse, sticky overflow (cleared by start)
module mask_wb_packer #(
    parameter int VLEN       = 16384,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int DW_B       = DATA_WIDTH / 8,
    parameter int OFF_BITS   = 8,
    parameter int CNT_W      = $clog2(DW_B) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_vd,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW_B-1:0]       in_bits,
    input  logic [CNT_W-1:0]      in_cnt,
    input  logic                  in_last,
    output logic [DW_B-1:0]       wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [OFF_BITS-1:0]   wr_off,
    output logic [DATA_WIDTH-1:0] wr_data_in,
    output logic                  done,
    output logic                  ovf
);

    localparam int                  WORDS    = VLEN / DATA_WIDTH;
    localparam logic [OFF_BITS-1:0] LAST_OFF = OFF_BITS'(WORDS - 1);
    localparam logic [CNT_W:0]      DWB_V    = (CNT_W + 1)'(DW_B);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                r_state;
    logic [DW_B-1:0]       r_acc;
    logic [CNT_W-1:0]      r_fill;
    logic [OFF_BITS-1:0]   r_off;
    // Set once a word has been written at LAST_OFF; every later write is past the register end.
    logic                  r_end;
    logic                  r_busy;
    logic                  r_in_ready;
    logic [DW_B-1:0]       r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [OFF_BITS-1:0]   r_wr_off;
    logic [DW_B-1:0]       r_wr_data;
    logic                  r_done;
    logic                  r_ovf;

    logic [DW_B-1:0]       w_bits;
    logic [2*DW_B-1:0]     w_comb;
    logic [CNT_W:0]        w_nf;
    logic [CNT_W:0]        w_rem;
    logic                  w_full;
    logic [DW_B-1:0]       w_part_en;
    logic [DW_B-1:0]       w_flush_en;

    // Bits at and above in_cnt are don't-care from the ALU, so clear them before merging.
    assign w_bits     = in_bits & ~({DW_B{1'b1}} << in_cnt);
    assign w_comb     = {{DW_B{1'b0}}, r_acc} | ({{DW_B{1'b0}}, w_bits} << r_fill);
    assign w_nf       = {1'b0, r_fill} + {1'b0, in_cnt};
    assign w_full     = (w_nf >= DWB_V);
    assign w_rem      = w_nf - DWB_V;
    assign w_part_en  = ~({DW_B{1'b1}} << w_nf);
    assign w_flush_en = ~({DW_B{1'b1}} << r_fill);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_fill     <= '0;
            r_off      <= '0;
            r_end      <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_off   <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_wr_en <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wr_addr  <= start_vd;
                        r_off      <= '0;
                        r_fill     <= '0;
                        r_acc      <= '0;
                        r_end      <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        if (w_full) begin
                            if (r_end) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_wr_en   <= '1;
                                r_wr_off  <= r_off;
                                r_wr_data <= w_comb[DW_B-1:0];
                            end
                            r_acc  <= w_comb[2*DW_B-1:DW_B];
                            r_fill <= w_rem[CNT_W-1:0];
                            // off saturates; r_end remembers that the last word is used.
                            if (r_off == LAST_OFF) begin
                                r_end <= 1'b1;
                            end else begin
                                r_off <= r_off + OFF_BITS'(1);
                            end
                        end else begin
                            r_acc  <= w_comb[DW_B-1:0];
                            r_fill <= w_nf[CNT_W-1:0];
                        end
                        if (in_last) begin
                            if (w_full && (w_rem != '0)) begin
                                r_in_ready <= 1'b0;
                                r_state    <= S_FLUSH;
                            end else begin
                                if (!w_full && (w_nf != '0)) begin
                                    if (r_end) begin
                                        r_ovf <= 1'b1;
                                    end else begin
                                        r_wr_en   <= w_part_en;
                                        r_wr_off  <= r_off;
                                        r_wr_data <= w_comb[DW_B-1:0] & w_part_en;
                                    end
                                end
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_in_ready <= 1'b0;
                                r_state    <= S_IDLE;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_end) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_wr_en   <= w_flush_en;
                        r_wr_off  <= r_off;
                        r_wr_data <= r_acc & w_flush_en;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_off     = r_wr_off;
    assign wr_data_in = {{(DATA_WIDTH - DW_B){1'b0}}, r_wr_data};
    assign done       = r_done;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_mask_wb_packer.sv
// Bench for mask_wb_packer: one full-size instance and one VLEN=128 instance share the inputs.
// Expected writes are queued when beats are driven and compared as the selected instance emits them.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
module tb_mask_wb_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_vd = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_bits = '0;
    logic [3:0]  in_cnt = '0;
    logic        in_last = 1'b0;

    logic        busy_a, in_ready_a, done_a, ovf_a;
    logic [7:0]  wr_en_a, wr_off_a;
    logic [4:0]  wr_addr_a;
    logic [63:0] wr_data_a;
    logic        busy_b, in_ready_b, done_b, ovf_b;
    logic [7:0]  wr_en_b, wr_off_b;
    logic [4:0]  wr_addr_b;
    logic [63:0] wr_data_b;

    always #5 clk = ~clk;

    mask_wb_packer u_dut_a (
        .clk(clk), .rst(rst), .start(start), .start_vd(start_vd), .busy(busy_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_bits(in_bits), .in_cnt(in_cnt),
        .in_last(in_last), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_off(wr_off_a),
        .wr_data_in(wr_data_a), .done(done_a), .ovf(ovf_a)
    );

    mask_wb_packer #(.VLEN(128)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .start_vd(start_vd), .busy(busy_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_bits(in_bits), .in_cnt(in_cnt),
        .in_last(in_last), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_off(wr_off_b),
        .wr_data_in(wr_data_b), .done(done_b), .ovf(ovf_b)
    );

    typedef struct packed {
        logic [7:0]  en;
        logic [4:0]  addr;
        logic [7:0]  off;
        logic [63:0] data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   sel   = 1'b0;

    task automatic push(input logic [7:0] en, input logic [4:0] addr, input logic [7:0] off,
                        input logic [7:0] data, input logic dn);
        exp_t e;
        e.en = en; e.addr = addr; e.off = off; e.data = {56'd0, data}; e.done = dn;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every cycle with a write or done must match the next queued expectation.
    always @(negedge clk) begin
        logic [7:0]  en, off;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        dn;
        exp_t        e;
        if (sel) begin en = wr_en_b; addr = wr_addr_b; off = wr_off_b; data = wr_data_b; dn = done_b; end
        else     begin en = wr_en_a; addr = wr_addr_a; off = wr_off_a; data = wr_data_a; dn = done_a; end
        if (!rst && (en != 8'h00 || dn)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got en=%h addr=%0d off=%0d data=%h done=%b, none expected",
                         en, addr, off, data, dn);
            end else begin
                e = exp_q.pop_front();
                if (en !== e.en || dn !== e.done ||
                    (e.en != 8'h00 && (addr !== e.addr || off !== e.off || data !== e.data))) begin
                    fails++;
                    $display("FAIL write: got en=%h addr=%0d off=%0d data=%h done=%b, want en=%h addr=%0d off=%0d data=%h done=%b",
                             en, addr, off, data, dn, e.en, e.addr, e.off, e.data, e.done);
                end
            end
        end
    end

    task automatic start_op(input logic [4:0] vd);
        start = 1'b1; start_vd = vd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] bits, input logic [3:0] cnt, input logic last);
        in_valid = 1'b1; in_bits = bits; in_cnt = cnt; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Bounded wait for all queued writes to appear; ends with the operation idle.
    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d writes still outstanding, want 0", name, exp_q.size());
        end
        tests++;
        if ((sel ? busy_b : busy_a) !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: busy=%b, want 0", name, sel ? busy_b : busy_a);
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({busy_a, in_ready_a, wr_en_a, wr_addr_a, wr_off_a, wr_data_a, done_a, ovf_a} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b rdy=%b en=%h addr=%0d off=%0d data=%h done=%b ovf=%b, want all 0",
                     busy_a, in_ready_a, wr_en_a, wr_addr_a, wr_off_a, wr_data_a, done_a, ovf_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_words;
        sel = 1'b0;
        start_op(5'd3);
        tests++;
        if (busy_a !== 1'b1 || in_ready_a !== 1'b1) begin
            fails++;
            $display("FAIL start_flags: busy=%b in_ready=%b, want 1 1", busy_a, in_ready_a);
        end
        for (int k = 0; k < 8; k++) begin
            push(8'hFF, 5'd3, 8'(k), 8'(k + 1), k == 7);
            tests++;
            if (in_ready_a !== 1'b1) begin
                fails++;
                $display("FAIL no_bubble: in_ready=%b at beat %0d, want 1", in_ready_a, k);
            end
            beat(8'(k + 1), 4'd8, k == 7);
        end
        drain("full_words");
    endtask

    task automatic test_flush;
        sel = 1'b0;
        start_op(5'd1);
        beat(8'b101, 4'd3, 1'b0);
        beat(8'b101, 4'd3, 1'b0);
        push(8'hFF, 5'd1, 8'd0, 8'h6D, 1'b0);
        push(8'h01, 5'd1, 8'd1, 8'h01, 1'b1);
        beat(8'b101, 4'd3, 1'b1);
        @(posedge clk); #1;
        tests++;
        if (in_ready_a !== 1'b0 || done_a !== 1'b1) begin
            fails++;
            $display("FAIL flush_cycle: in_ready=%b done=%b, want 0 1", in_ready_a, done_a);
        end
        drain("flush");
    endtask

    task automatic test_single_partial;
        sel = 1'b0;
        start_op(5'd6);
        push(8'h1F, 5'd6, 8'd0, 8'h1F, 1'b1);
        beat(8'hFF, 4'd5, 1'b1);
        drain("single_partial");
    endtask

    task automatic test_overflow;
        sel = 1'b1;
        start_op(5'd2);
        push(8'hFF, 5'd2, 8'd0, 8'hA1, 1'b0);
        beat(8'hA1, 4'd8, 1'b0);
        push(8'hFF, 5'd2, 8'd1, 8'hA2, 1'b0);
        beat(8'hA2, 4'd8, 1'b0);
        push(8'h00, 5'd2, 8'd0, 8'h00, 1'b1);
        beat(8'hA3, 4'd8, 1'b1);
        drain("overflow");
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (ovf_b !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: ovf=%b, want 1", ovf_b);
        end
        start_op(5'd2);
        tests++;
        if (ovf_b !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b after start, want 0", ovf_b);
        end
        push(8'h00, 5'd2, 8'd0, 8'h00, 1'b1);
        beat(8'h00, 4'd0, 1'b1);
        drain("ovf_clear_op");
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        sel = 1'b0;
        start_op(5'd4);
        beat(8'h0F, 4'd4, 1'b0);
        // rst arrives while the second beat is on the bus, so that beat never lands.
        in_valid = 1'b1; in_bits = 8'h0F; in_cnt = 4'd4; rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy_a, in_ready_a, wr_en_a, wr_addr_a, wr_off_a, wr_data_a, done_a, ovf_a} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: busy=%b rdy=%b en=%h addr=%0d off=%0d data=%h done=%b, want all 0",
                     busy_a, in_ready_a, wr_en_a, wr_addr_a, wr_off_a, wr_data_a, done_a);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_op(5'd7);
        push(8'hFF, 5'd7, 8'd0, 8'h5A, 1'b1);
        beat(8'h5A, 4'd8, 1'b1);
        drain("reset_mid_op");
    endtask

    task automatic test_empty_last;
        sel = 1'b0;
        start_op(5'd5);
        push(8'h00, 5'd5, 8'd0, 8'h00, 1'b1);
        beat(8'hFF, 4'd0, 1'b1);
        drain("empty_last");
    endtask

    task automatic test_start_while_busy;
        sel = 1'b0;
        start_op(5'd2);
        start_op(5'd9);
        tests++;
        if (busy_a !== 1'b1 || wr_addr_a !== 5'd2) begin
            fails++;
            $display("FAIL busy_start: busy=%b wr_addr=%0d, want 1 2", busy_a, wr_addr_a);
        end
        push(8'hFF, 5'd2, 8'd0, 8'hC3, 1'b1);
        beat(8'hC3, 4'd8, 1'b1);
        drain("start_while_busy");
    endtask

    task automatic test_back_to_back;
        // Unaligned 6-bit beats straddle word boundaries: elements 0..17 of 6'b110011 repeated.
        sel = 1'b0;
        start_op(5'd8);
        push(8'hFF, 5'd8, 8'd0, 8'hF3, 1'b0);
        push(8'hFF, 5'd8, 8'd1, 8'h3C, 1'b0);
        push(8'h03, 5'd8, 8'd2, 8'h03, 1'b1);
        beat(8'hF3, 4'd6, 1'b0);
        beat(8'h33, 4'd6, 1'b0);
        beat(8'h33, 4'd6, 1'b1);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_flush();
        test_single_partial();
        test_overflow();
        test_reset_mid_op();
        test_empty_last();
        test_start_while_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
